// File: rtl/decode_hazard_ctrl_if.sv
// ============================================================================
// Module  : decode_hazard_ctrl_if
// Brief   : Decode-stage / writeback bundle seen by the hazard controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface decode_hazard_ctrl_if #(
   parameter int REGISTER_SIZE = 5,
   parameter int STALL_CNT_W   = 16
);
   logic                          dec_valid;
   logic [REGISTER_SIZE-1:0]      dec_rs1_addr;
   logic                          dec_rs1_used;
   logic [REGISTER_SIZE-1:0]      dec_rs2_addr;
   logic                          dec_rs2_used;
   logic [REGISTER_SIZE-1:0]      dec_rd_addr;
   logic                          dec_rd_write;
   logic                          dec_redirect;
   logic                          wb_enable;
   logic [REGISTER_SIZE-1:0]      wb_addr;
   logic                          issue;
   logic                          stall;
   logic                          flush;
   logic [(2**REGISTER_SIZE)-1:0] busy_regs;
   logic [STALL_CNT_W-1:0]        stall_count;

   modport master (
      output dec_valid, dec_rs1_addr, dec_rs1_used, dec_rs2_addr, dec_rs2_used,
             dec_rd_addr, dec_rd_write, dec_redirect, wb_enable, wb_addr,
      input  issue, stall, flush, busy_regs, stall_count
   );

   modport slave (
      input  dec_valid, dec_rs1_addr, dec_rs1_used, dec_rs2_addr, dec_rs2_used,
             dec_rd_addr, dec_rd_write, dec_redirect, wb_enable, wb_addr,
      output issue, stall, flush, busy_regs, stall_count
   );
endinterface

`default_nettype wire

// File: rtl/decode_hazard_ctrl.sv
// ============================================================================
// Module  : decode_hazard_ctrl
// Brief   : Scoreboard stall/flush controller for the decode stage.
//           Optional macro HAZARD_WB_BYPASS_EN: same-cycle writeback bypass.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_hazard_ctrl #(
   parameter int REGISTER_SIZE = 5,
   parameter int PEND_CNT_W    = 2,
   parameter int FLUSH_CYCLES  = 1,
   parameter int STALL_CNT_W   = 16
) (
   input  wire logic           clk,
   input  wire logic           rst,
   decode_hazard_ctrl_if.slave bus
);

   localparam int                    c_nreg     = 2**REGISTER_SIZE;
   localparam logic [PEND_CNT_W-1:0] c_pend_max = '1;
   localparam logic [PEND_CNT_W-1:0] c_pend_one = PEND_CNT_W'(1);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nx;
   logic [2:0]              r_flush_cnt;
   logic [2:0]              w_flush_cnt_nx;
   logic [PEND_CNT_W-1:0]   r_pending [c_nreg];
   logic [STALL_CNT_W-1:0]  r_stall_count;

   logic [PEND_CNT_W-1:0]   w_pend_rs1;
   logic [PEND_CNT_W-1:0]   w_pend_rs2;
   logic [PEND_CNT_W-1:0]   w_pend_rd;
   logic                    w_raw1;
   logic                    w_raw2;
   logic                    w_sat;
   logic                    w_hazard;
   logic                    w_issue;
   logic                    w_stall;
   logic                    w_flush;
   logic [c_nreg-1:0]       w_inc;
   logic [c_nreg-1:0]       w_dec;
   logic [c_nreg-1:0]       w_busy;

   assign w_pend_rs1 = r_pending[bus.dec_rs1_addr];
   assign w_pend_rs2 = r_pending[bus.dec_rs2_addr];
   assign w_pend_rd  = r_pending[bus.dec_rd_addr];

`ifdef HAZARD_WB_BYPASS_EN
   // The last outstanding write retiring this cycle is forwarded to decode.
   logic w_byp1;
   logic w_byp2;
   assign w_byp1 = (w_pend_rs1 == c_pend_one) && bus.wb_enable && (bus.wb_addr == bus.dec_rs1_addr);
   assign w_byp2 = (w_pend_rs2 == c_pend_one) && bus.wb_enable && (bus.wb_addr == bus.dec_rs2_addr);
   assign w_raw1 = bus.dec_rs1_used && (bus.dec_rs1_addr != '0) && (w_pend_rs1 != '0) && !w_byp1;
   assign w_raw2 = bus.dec_rs2_used && (bus.dec_rs2_addr != '0) && (w_pend_rs2 != '0) && !w_byp2;
`else
   assign w_raw1 = bus.dec_rs1_used && (bus.dec_rs1_addr != '0) && (w_pend_rs1 != '0);
   assign w_raw2 = bus.dec_rs2_used && (bus.dec_rs2_addr != '0) && (w_pend_rs2 != '0);
`endif

   assign w_sat    = bus.dec_rd_write && (bus.dec_rd_addr != '0) && (w_pend_rd == c_pend_max);
   assign w_hazard = bus.dec_valid && (w_raw1 || w_raw2 || w_sat);

   always_comb begin
      w_state_nx     = r_state;
      w_flush_cnt_nx = r_flush_cnt;
      w_issue        = 1'b0;
      w_stall        = 1'b0;
      w_flush        = 1'b0;
      case (r_state)
         ST_FLUSH: begin
            w_flush        = 1'b1;
            w_flush_cnt_nx = r_flush_cnt - 3'd1;
            if (r_flush_cnt <= 3'd1) begin
               w_state_nx = ST_RUN;
            end
         end
         default: begin
            w_issue = bus.dec_valid && !w_hazard;
            w_stall = w_hazard;
            if (w_hazard) begin
               w_state_nx = ST_STALL;
            end else if (w_issue && bus.dec_redirect) begin
               w_state_nx     = ST_FLUSH;
               w_flush_cnt_nx = 3'(FLUSH_CYCLES);
            end else begin
               w_state_nx = ST_RUN;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_RUN;
         r_flush_cnt <= 3'd0;
      end else begin
         r_state     <= w_state_nx;
         r_flush_cnt <= w_flush_cnt_nx;
      end
   end

   // x0 is excluded here so its counter stays at zero forever.
   for (genvar gi = 0; gi < c_nreg; gi++) begin : g_sb
      assign w_inc[gi]  = (gi != 0) && w_issue && bus.dec_rd_write &&
                          (bus.dec_rd_addr == REGISTER_SIZE'(gi));
      assign w_dec[gi]  = (gi != 0) && bus.wb_enable &&
                          (bus.wb_addr == REGISTER_SIZE'(gi)) && (r_pending[gi] != '0);
      assign w_busy[gi] = (r_pending[gi] != '0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < c_nreg; i++) begin
            r_pending[i] <= '0;
         end
      end else begin
         for (int i = 0; i < c_nreg; i++) begin
            if (w_inc[i] && !w_dec[i]) begin
               r_pending[i] <= r_pending[i] + c_pend_one;
            end else if (w_dec[i] && !w_inc[i]) begin
               r_pending[i] <= r_pending[i] - c_pend_one;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall_count <= '0;
      end else if (w_stall && (r_stall_count != '1)) begin
         r_stall_count <= r_stall_count + STALL_CNT_W'(1);
      end
   end

   assign bus.issue       = w_issue;
   assign bus.stall       = w_stall;
   assign bus.flush       = w_flush;
   assign bus.busy_regs   = w_busy;
   assign bus.stall_count = r_stall_count;

endmodule

`default_nettype wire

// File: tb/tb_decode_hazard_ctrl.sv
// Directed-vector bench for decode_hazard_ctrl (FLUSH_CYCLES = 2).
// Expected values are hand-derived; HAZARD_WB_BYPASS_EN selects the bypass timing.
`default_nettype none

module tb_decode_hazard_ctrl;

   logic clk;
   logic rst;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   exp_sc   = 0;

   decode_hazard_ctrl_if #(.REGISTER_SIZE(5), .STALL_CNT_W(16)) bus ();

   decode_hazard_ctrl #(
      .REGISTER_SIZE(5),
      .PEND_CNT_W   (2),
      .FLUSH_CYCLES (2),
      .STALL_CNT_W  (16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic set_dec(input logic v, input logic [4:0] rs1, input logic r1u,
                          input logic [4:0] rs2, input logic r2u,
                          input logic [4:0] rd, input logic rdw, input logic redir);
      bus.dec_valid    = v;
      bus.dec_rs1_addr = rs1;
      bus.dec_rs1_used = r1u;
      bus.dec_rs2_addr = rs2;
      bus.dec_rs2_used = r2u;
      bus.dec_rd_addr  = rd;
      bus.dec_rd_write = rdw;
      bus.dec_redirect = redir;
   endtask

   task automatic set_wb(input logic e, input logic [4:0] a);
      bus.wb_enable = e;
      bus.wb_addr   = a;
   endtask

   task automatic idle();
      set_dec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   // Check combinational outputs for the current inputs, then advance one clock.
   task automatic cyc(input string tag, input logic ei, input logic es, input logic ef);
      #1;
      check({tag, ".issue"}, 32'(bus.issue), 32'(ei));
      check({tag, ".stall"}, 32'(bus.stall), 32'(es));
      check({tag, ".flush"}, 32'(bus.flush), 32'(ef));
      @(posedge clk);
      if (es) exp_sc++;
      #1;
   endtask

   task automatic chk_busy(input string tag, input logic [31:0] exp);
      check(tag, bus.busy_regs, exp);
   endtask

   task automatic chk_sc(input string tag);
      check(tag, 32'(bus.stall_count), 32'(exp_sc));
   endtask

   initial begin
      rst = 1'b0;
      idle();
      set_wb(1'b0, 5'd0);
      #2;
      chk_busy("rst_busy", 32'h0);
      check("rst_flush", 32'(bus.flush), 32'h0);
      check("rst_sc", 32'(bus.stall_count), 32'h0);
      check("rst_stall", 32'(bus.stall), 32'h0);
      @(posedge clk); #1;
      rst = 1'b1;

      // RAW on x5 with writeback release
      set_dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
      cyc("iss5", 1'b1, 1'b0, 1'b0);
      chk_busy("busy5", 32'h0000_0020);
      set_dec(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
      cyc("raw_a", 1'b0, 1'b1, 1'b0);
      chk_sc("sc_raw_a");
      cyc("raw_b", 1'b0, 1'b1, 1'b0);
      chk_sc("sc_raw_b");
      set_wb(1'b1, 5'd5);
`ifdef HAZARD_WB_BYPASS_EN
      cyc("wbN", 1'b1, 1'b0, 1'b0);
      set_wb(1'b0, 5'd0);
`else
      cyc("wbN", 1'b0, 1'b1, 1'b0);
      set_wb(1'b0, 5'd0);
      chk_busy("busy_wbN", 32'h0);
      cyc("wbN1", 1'b1, 1'b0, 1'b0);
`endif
      idle();
      chk_busy("busy6", 32'h0000_0040);
      chk_sc("sc_raw_end");
      set_wb(1'b1, 5'd6);
      cyc("ret6", 1'b0, 1'b0, 1'b0);
      set_wb(1'b0, 5'd0);
      chk_busy("busy_ret6", 32'h0);

      // x0 is never tracked
      set_dec(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cyc("x0", 1'b1, 1'b0, 1'b0);
      chk_busy("busy_x0", 32'h0);

      // Saturation on x7
      set_dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cyc("fill7", 1'b1, 1'b0, 1'b0);
      chk_busy("busy7", 32'h0000_0080);
      cyc("sat", 1'b0, 1'b1, 1'b0);
      set_wb(1'b1, 5'd7);
      cyc("sat_wb", 1'b0, 1'b1, 1'b0);
      set_wb(1'b0, 5'd0);
      cyc("sat_go", 1'b1, 1'b0, 1'b0);
      idle();
      set_wb(1'b1, 5'd7);
      cyc("drain7a", 1'b0, 1'b0, 1'b0);
      cyc("drain7b", 1'b0, 1'b0, 1'b0);
      chk_busy("busy7_left1", 32'h0000_0080);
      cyc("drain7c", 1'b0, 1'b0, 1'b0);
      set_wb(1'b0, 5'd0);
      chk_busy("busy7_empty", 32'h0);
      chk_sc("sc_sat");

      // Redirect: flush exactly two cycles, decode inputs ignored meanwhile
      set_dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
      cyc("redir", 1'b1, 1'b0, 1'b0);
      set_dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);
      cyc("fl1", 1'b0, 1'b0, 1'b1);
      cyc("fl2", 1'b0, 1'b0, 1'b1);
      set_dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      cyc("after_fl", 1'b1, 1'b0, 1'b0);
      chk_busy("busy_fl", 32'h0);

      // Hazard plus redirect: stall first, flush only after issue
      set_dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
      cyc("iss10", 1'b1, 1'b0, 1'b0);
      set_dec(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
      cyc("hr_s1", 1'b0, 1'b1, 1'b0);
      cyc("hr_s2", 1'b0, 1'b1, 1'b0);
      set_wb(1'b1, 5'd10);
`ifdef HAZARD_WB_BYPASS_EN
      cyc("hr_wb", 1'b1, 1'b0, 1'b0);
      set_wb(1'b0, 5'd0);
`else
      cyc("hr_wb", 1'b0, 1'b1, 1'b0);
      set_wb(1'b0, 5'd0);
      cyc("hr_go", 1'b1, 1'b0, 1'b0);
`endif
      cyc("hr_fl1", 1'b0, 1'b0, 1'b1);
      cyc("hr_fl2", 1'b0, 1'b0, 1'b1);
      idle();
      cyc("hr_run", 1'b0, 1'b0, 1'b0);
      chk_sc("sc_hr");

      // Same-cycle inc/dec on x9, and writeback to an idle register
      set_dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
      cyc("iss9", 1'b1, 1'b0, 1'b0);
      set_wb(1'b1, 5'd9);
      cyc("iss9_wb9", 1'b1, 1'b0, 1'b0);
      idle();
      chk_busy("busy9_kept", 32'h0000_0200);
      cyc("ret9", 1'b0, 1'b0, 1'b0);
      chk_busy("busy9_clr", 32'h0);
      set_wb(1'b1, 5'd12);
      cyc("wb12", 1'b0, 1'b0, 1'b0);
      set_wb(1'b0, 5'd0);
      chk_busy("busy12_noudf", 32'h0);

      // Asynchronous reset while flushing
      set_dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 1'b1);
      cyc("rf_redir", 1'b1, 1'b0, 1'b0);
      idle();
      #1;
      check("rf_pre_flush", 32'(bus.flush), 32'h1);
      chk_busy("rf_pre_busy", 32'h0000_0800);
      rst = 1'b0;
      #1;
      check("rf_flush", 32'(bus.flush), 32'h0);
      chk_busy("rf_busy", 32'h0);
      check("rf_sc", 32'(bus.stall_count), 32'h0);
      exp_sc = 0;
      #1;
      rst = 1'b1;
      set_dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      cyc("rf_run", 1'b1, 1'b0, 1'b0);

      // Asynchronous reset while stalled
      set_dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0);
      cyc("rs_iss13", 1'b1, 1'b0, 1'b0);
      set_dec(1'b1, 5'd13, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      cyc("rs_s1", 1'b0, 1'b1, 1'b0);
      cyc("rs_s2", 1'b0, 1'b1, 1'b0);
      chk_sc("rs_sc_pre");
      rst = 1'b0;
      #1;
      chk_busy("rs_busy", 32'h0);
      check("rs_sc", 32'(bus.stall_count), 32'h0);
      check("rs_stall", 32'(bus.stall), 32'h0);
      exp_sc = 0;
      #1;
      rst = 1'b1;
      cyc("rs_run", 1'b1, 1'b0, 1'b0);
      idle();
      cyc("rs_idle", 1'b0, 1'b0, 1'b0);
      chk_sc("sc_final");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
